bcnn_layer_sequencer: RTL and testbench
=======================================

BCNN_LAYER_SEQUENCER -- requirements
Module: bcnn_layer_sequencer

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 28, input image columns.
REQ-002 SHALL have parameter IMG_HEIGHT, default 28, input image rows.
REQ-003 SHALL have parameter KERNEL_SIZE, default 3, convolution window edge.
REQ-004 SHALL have parameter NUM_KERNELS, default 8, number of kernels applied per frame.
REQ-005 SHALL have parameter DRAIN_TIMEOUT, default 1024, maximum DRAIN cycles before error.
REQ-006 Derived: NPIX=IMG_WIDTH*IMG_HEIGHT (784); NPOOL=((IMG_WIDTH-KERNEL_SIZE+1)/2)*((IMG_HEIGHT-KERNEL_SIZE+1)/2) (169); AW=$clog2(NPIX); KW=$clog2(NUM_KERNELS); PW=$clog2(NPOOL).
REQ-007 clk  in  1  single clock, all logic on rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 start  in  1  frame start request.
REQ-010 stall  in  1  when high, no new image read is issued.
REQ-011 wload_en / wload_idx / wload_data  in  1 / KW / KERNEL_SIZE^2  weight register write port.
REQ-012 img_rd_en / img_addr  out  1 / AW  image memory read request.
REQ-013 img_rd_data  in  1  image memory read data, valid one cycle after img_rd_en.
REQ-014 pix_out / pix_valid  out  1 / 1  drive datapath pixel_in / valid_in.
REQ-015 weight_bits  out  KERNEL_SIZE^2  weights of current kernel.
REQ-016 pipe_clear  out  1  one-cycle active-high datapath reset pulse.
REQ-017 pool_out / pool_valid  in  1 / 1  pooled result from datapath.
REQ-018 res_valid / res_data / res_kernel / res_index  out  1 / 1 / KW / PW  tagged result stream.
REQ-019 busy / done / error  out  1 / 1 / 1  status.

Function
REQ-020 FSM states SHALL be IDLE, CLEAR, STREAM, DRAIN, NEXT, DONE.
REQ-021 IDLE: start=1 -> CLEAR, kernel_idx=0, error cleared; start in any other state ignored.
REQ-022 CLEAR: pipe_clear=1 for exactly one cycle, pixel and pool counters zeroed -> STREAM.
REQ-023 STREAM: each cycle with stall=0, img_rd_en=1, img_addr=pixel counter, counter++; after address NPIX-1 issued -> DRAIN.
REQ-024 pix_valid SHALL equal img_rd_en delayed one cycle; pix_out=img_rd_data in that cycle; stall gaps produce pix_valid=0.
REQ-025 Pool counter SHALL count pool_valid in STREAM and DRAIN only; pool_valid in IDLE/CLEAR/NEXT/DONE or beyond NPOOL ignored.
REQ-026 Each counted pool_valid SHALL produce res_valid=1 one cycle later with res_data=pool_out, res_kernel=kernel_idx, res_index=pool count before increment.
REQ-027 DRAIN: pool count reaching NPOOL -> NEXT; DRAIN_TIMEOUT cycles in DRAIN without completion -> error=1, -> DONE.
REQ-028 NEXT: kernel_idx==NUM_KERNELS-1 -> DONE, else kernel_idx++ -> CLEAR.
REQ-029 DONE: done=1 for one cycle -> IDLE; error held until next accepted start.
REQ-030 busy=1 in every state except IDLE.
REQ-031 weight_bits SHALL be weight register[kernel_idx], stable from CLEAR through DRAIN.
REQ-032 wload_en SHALL write register[wload_idx] only when busy=0; ignored when busy=1; wload_idx>=NUM_KERNELS ignored.
REQ-033 stall in DRAIN has no effect; stall asserted on the cycle STREAM would issue NPIX-1 delays that issue.

Reset
REQ-034 reset=0 SHALL asynchronously force IDLE, all counters 0, kernel_idx 0, all weight registers 0, and outputs img_rd_en, pix_valid, pix_out, pipe_clear, res_valid, res_data, res_kernel, res_index, busy, done, error to 0.
REQ-035 Reset mid-frame SHALL abandon the frame; no done pulse follows.

Structure
REQ-036 FSM state encoding and derived constants NPIX/NPOOL SHALL live in shared package bcnn_pkg.
REQ-037 Weight register file SHALL be one sub-module bcnn_weight_regs; counters and FSM stay in the top.

Verification
REQ-038 Load 8 kernels, start, ideal datapath model -> exactly 8x784 pix_valid, 8x169 res_valid, res_index 0..168 per kernel, done pulse once, error=0.
REQ-039 stall high every third STREAM cycle -> same pixel sequence and img_addr order 0..783, STREAM length 1176 cycles per kernel.
REQ-040 Datapath model withholds pool_valid after 100 results -> error=1 exactly 1024 cycles into DRAIN, done pulses, busy falls.
REQ-041 wload_en while busy with wload_idx=0 -> weight_bits for kernel 0 unchanged on the next frame.
REQ-042 reset=0 during STREAM of kernel 3 -> all outputs 0 immediately, IDLE, no done; subsequent start runs full 8 kernels.
REQ-043 start pulsed during DRAIN and DONE -> ignored; pipe_clear pulses exactly 8 times per frame.

Source files
------------

// File: rtl/bcnn_pkg.sv
// Shared FSM encoding and geometry helpers for the binary CNN layer sequencer.
// Default-geometry constants are provided for blocks that do not re-derive them.
package bcnn_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StStream,
        StDrain,
        StNext,
        StDone
    } state_e;

    function automatic int unsigned calc_npix(input int unsigned w, input int unsigned h);
        return w * h;
    endfunction

    // Valid-convolution output size halved by 2x2 pooling in each dimension.
    function automatic int unsigned calc_npool(input int unsigned w, input int unsigned h,
                                               input int unsigned k);
        return ((w - k + 1) / 2) * ((h - k + 1) / 2);
    endfunction

    localparam int unsigned NPIX  = calc_npix(28, 28);
    localparam int unsigned NPOOL = calc_npool(28, 28, 3);

endpackage

// File: rtl/bcnn_weight_regs.sv
// Per-kernel binary weight register file: one write port, one combinational read port.
// Writes to indices beyond the kernel count are dropped.
module bcnn_weight_regs #(
    parameter int unsigned NUM_KERNELS = 8,
    parameter int unsigned WBITS       = 9,
    parameter int unsigned KW          = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [KW-1:0]    widx_i,
    input  logic [WBITS-1:0] wdata_i,
    input  logic [KW-1:0]    ridx_i,
    output logic [WBITS-1:0] rdata_o
);

    logic [WBITS-1:0] regs_q [NUM_KERNELS];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NUM_KERNELS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (32'(widx_i) < NUM_KERNELS)) begin
            regs_q[widx_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_o = '0;
        if (32'(ridx_i) < NUM_KERNELS) begin
            rdata_o = regs_q[ridx_i];
        end
    end

endmodule

// File: rtl/bcnn_layer_sequencer.sv
// Frame sequencer for a binary CNN layer: streams the image once per kernel, tags pooled
// results with kernel and position, and flags a datapath that stops producing results.
module bcnn_layer_sequencer
    import bcnn_pkg::*;
#(
    parameter int unsigned IMG_WIDTH     = 28,
    parameter int unsigned IMG_HEIGHT    = 28,
    parameter int unsigned KERNEL_SIZE   = 3,
    parameter int unsigned NUM_KERNELS   = 8,
    parameter int unsigned DRAIN_TIMEOUT = 1024,
    localparam int unsigned Npix  = calc_npix(IMG_WIDTH, IMG_HEIGHT),
    localparam int unsigned Npool = calc_npool(IMG_WIDTH, IMG_HEIGHT, KERNEL_SIZE),
    localparam int unsigned AW    = $clog2(Npix),
    localparam int unsigned KW    = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1,
    localparam int unsigned PW    = (Npool > 1) ? $clog2(Npool) : 1,
    localparam int unsigned WBITS = KERNEL_SIZE * KERNEL_SIZE
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             wload_en_i,
    input  logic [KW-1:0]    wload_idx_i,
    input  logic [WBITS-1:0] wload_data_i,
    output logic             img_rd_en_o,
    output logic [AW-1:0]    img_addr_o,
    input  logic             img_rd_data_i,
    output logic             pix_out_o,
    output logic             pix_valid_o,
    output logic [WBITS-1:0] weight_bits_o,
    output logic             pipe_clear_o,
    input  logic             pool_out_i,
    input  logic             pool_valid_i,
    output logic             res_valid_o,
    output logic             res_data_o,
    output logic [KW-1:0]    res_kernel_o,
    output logic [PW-1:0]    res_index_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o
);

    localparam int unsigned DW = $clog2(DRAIN_TIMEOUT + 1);

    localparam logic [AW-1:0] LastAddr  = AW'(Npix - 1);
    localparam logic [PW:0]   PoolMax   = (PW + 1)'(Npool);
    localparam logic [DW-1:0] DrainLast = DW'(DRAIN_TIMEOUT - 1);
    localparam logic [KW-1:0] KernLast  = KW'(NUM_KERNELS - 1);

    state_e        state_q, state_d;
    logic [KW-1:0] kernel_q, kernel_d;
    logic [AW-1:0] pix_cnt_q, pix_cnt_d;
    logic [PW:0]   pool_cnt_q, pool_cnt_d;
    logic [DW-1:0] drain_cnt_q, drain_cnt_d;
    logic          error_q, error_d;
    logic          pix_valid_q;
    logic          res_valid_q, res_data_q;
    logic [KW-1:0] res_kernel_q;
    logic [PW-1:0] res_index_q;

    logic rd_en;
    logic clear;
    logic done;
    logic pool_take;
    logic wr_en;

    // Weights are frozen while a frame is in flight so every kernel sees one weight set.
    assign wr_en = wload_en_i && (state_q == StIdle);

    bcnn_weight_regs #(
        .NUM_KERNELS(NUM_KERNELS),
        .WBITS      (WBITS),
        .KW         (KW)
    ) u_weight_regs (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .we_i   (wr_en),
        .widx_i (wload_idx_i),
        .wdata_i(wload_data_i),
        .ridx_i (kernel_q),
        .rdata_o(weight_bits_o)
    );

    always_comb begin
        state_d     = state_q;
        kernel_d    = kernel_q;
        pix_cnt_d   = pix_cnt_q;
        pool_cnt_d  = pool_cnt_q;
        drain_cnt_d = drain_cnt_q;
        error_d     = error_q;
        rd_en       = 1'b0;
        clear       = 1'b0;
        done        = 1'b0;
        pool_take   = 1'b0;

        if (((state_q == StStream) || (state_q == StDrain)) && pool_valid_i &&
            (pool_cnt_q < PoolMax)) begin
            pool_take  = 1'b1;
            pool_cnt_d = pool_cnt_q + (PW + 1)'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d  = StClear;
                    kernel_d = '0;
                    error_d  = 1'b0;
                end
            end
            StClear: begin
                clear       = 1'b1;
                pix_cnt_d   = '0;
                pool_cnt_d  = '0;
                drain_cnt_d = '0;
                state_d     = StStream;
            end
            StStream: begin
                if (!stall_i) begin
                    rd_en     = 1'b1;
                    pix_cnt_d = pix_cnt_q + AW'(1);
                    if (pix_cnt_q == LastAddr) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                drain_cnt_d = drain_cnt_q + DW'(1);
                if (pool_cnt_q == PoolMax) begin
                    state_d = StNext;
                end else if (drain_cnt_q == DrainLast) begin
                    error_d = 1'b1;
                    state_d = StDone;
                end
            end
            StNext: begin
                if (kernel_q == KernLast) begin
                    state_d = StDone;
                end else begin
                    kernel_d = kernel_q + KW'(1);
                    state_d  = StClear;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            kernel_q     <= '0;
            pix_cnt_q    <= '0;
            pool_cnt_q   <= '0;
            drain_cnt_q  <= '0;
            error_q      <= 1'b0;
            pix_valid_q  <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= 1'b0;
            res_kernel_q <= '0;
            res_index_q  <= '0;
        end else begin
            state_q     <= state_d;
            kernel_q    <= kernel_d;
            pix_cnt_q   <= pix_cnt_d;
            pool_cnt_q  <= pool_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            error_q     <= error_d;
            pix_valid_q <= rd_en;
            res_valid_q <= pool_take;
            if (pool_take) begin
                res_data_q   <= pool_out_i;
                res_kernel_q <= kernel_q;
                res_index_q  <= pool_cnt_q[PW-1:0];
            end
        end
    end

    assign img_rd_en_o  = rd_en;
    assign img_addr_o   = pix_cnt_q;
    assign pix_valid_o  = pix_valid_q;
    // Memory data arrives one cycle after the request; gate it so idle cycles read as 0.
    assign pix_out_o    = pix_valid_q & img_rd_data_i;
    assign pipe_clear_o = clear;
    assign res_valid_o  = res_valid_q;
    assign res_data_o   = res_data_q;
    assign res_kernel_o = res_kernel_q;
    assign res_index_o  = res_index_q;
    assign busy_o       = (state_q != StIdle);
    assign done_o       = done;
    assign error_o      = error_q;

endmodule

// File: tb/tb_bcnn_layer_sequencer.sv
// Directed bench for bcnn_layer_sequencer with an image memory and an ideal pooling model.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_bcnn_layer_sequencer;

    localparam int NpixT  = 784;
    localparam int NpoolT = 169;
    localparam int NK     = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start, stall, wload_en;
    logic [2:0] wload_idx;
    logic [8:0] wload_data;
    logic       img_rd_en;
    logic [9:0] img_addr;
    logic       img_rd_data = 1'b0;
    logic       pix_out, pix_valid;
    logic [8:0] weight_bits;
    logic       pipe_clear;
    logic       pool_out, pool_valid;
    logic       res_valid, res_data;
    logic [2:0] res_kernel;
    logic [7:0] res_index;
    logic       busy, done, error;

    bcnn_layer_sequencer u_dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .stall_i      (stall),
        .wload_en_i   (wload_en),
        .wload_idx_i  (wload_idx),
        .wload_data_i (wload_data),
        .img_rd_en_o  (img_rd_en),
        .img_addr_o   (img_addr),
        .img_rd_data_i(img_rd_data),
        .pix_out_o    (pix_out),
        .pix_valid_o  (pix_valid),
        .weight_bits_o(weight_bits),
        .pipe_clear_o (pipe_clear),
        .pool_out_i   (pool_out),
        .pool_valid_i (pool_valid),
        .res_valid_o  (res_valid),
        .res_data_o   (res_data),
        .res_kernel_o (res_kernel),
        .res_index_o  (res_index),
        .busy_o       (busy),
        .done_o       (done),
        .error_o      (error)
    );

    function automatic logic memf(input int a);
        logic [9:0] v;
        v = a[9:0];
        return v[0] ^ v[3] ^ v[6] ^ v[9] ^ (v[2] & v[4]);
    endfunction

    function automatic logic poolf(input int k, input int i);
        logic [7:0] v;
        v = i[7:0];
        return (^v) ^ k[0] ^ k[1];
    endfunction

    // Image memory with one-cycle read latency.
    always @(posedge clk) begin
        img_rd_data <= img_rd_en ? memf(int'(img_addr)) : 1'b0;
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic       start_nx, stall_nx, pool_nx, pool_out_nx, wl_en_nx;
    logic [2:0] wl_idx_nx;
    logic [8:0] wl_data_nx;

    int  mk, clear_cnt, pix_seen, addr_seen, pools_sent, pool_limit;
    int  pix_total, res_total, done_cnt, stream_len, scyc, drain_t, err_delay, exp_stream_len;
    bit  in_stream, in_drain, err_seen, stall_mode, spam_mode, drain_any;
    logic [8:0]  exp_w [NK];
    logic [11:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic frame_reset();
        mk = 0; clear_cnt = 0; pix_seen = 0; addr_seen = 0; pools_sent = 0;
        pix_total = 0; res_total = 0; done_cnt = 0; stream_len = 0; scyc = 0;
        drain_t = 0; err_delay = -1;
        in_stream = 0; in_drain = 0; err_seen = 0; drain_any = 0;
        exp_q.delete();
    endtask

    task automatic monitor();
        logic [11:0] exp_r;
        pool_nx  = 1'b0;
        wl_en_nx = 1'b0;
        if (in_stream) stream_len++;
        if (in_drain) drain_t++;
        if (error && !err_seen) begin
            err_seen  = 1;
            err_delay = drain_t - 1;
        end
        if (pipe_clear) begin
            mk = clear_cnt % NK;
            clear_cnt++;
            check("weight_clear", 32'(weight_bits), 32'(exp_w[mk]));
            pix_seen = 0; addr_seen = 0; pools_sent = 0;
            in_stream = 1; stream_len = 0; scyc = 0; in_drain = 0;
        end
        if (img_rd_en) begin
            check("img_addr", 32'(img_addr), 32'(addr_seen));
            addr_seen++;
            if (addr_seen == NpixT) begin
                check("stream_len", 32'(stream_len), 32'(exp_stream_len));
                check("weight_drain", 32'(weight_bits), 32'(exp_w[mk]));
                in_stream = 0; in_drain = 1; drain_any = 1; drain_t = 0;
            end
        end
        if (res_valid) begin
            if (exp_q.size() == 0) begin
                check("res_unexpected", 32'(res_valid), 32'(0));
            end else begin
                exp_r = exp_q.pop_front();
                check("res_tag", 32'({res_kernel, res_index, res_data}), 32'(exp_r));
            end
            res_total++;
        end
        if (pix_valid) begin
            check("pix_out", 32'(pix_out), 32'(memf(pix_seen)));
            pix_seen++;
            pix_total++;
            if ((pix_seen % 4 == 0) && (pools_sent < pool_limit)) begin
                pool_nx     = 1'b1;
                pool_out_nx = poolf(mk, pools_sent);
                exp_q.push_back({mk[2:0], pools_sent[7:0], pool_out_nx});
                pools_sent++;
            end
        end
        if (done) done_cnt++;
        stall_nx = 1'b0;
        if (in_stream) begin
            stall_nx = stall_mode && (scyc % 3 == 0);
            scyc++;
        end
        start_nx = spam_mode && drain_any && busy && !done;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        start      = start_nx;
        stall      = stall_nx;
        pool_valid = pool_nx;
        pool_out   = pool_out_nx;
        wload_en   = wl_en_nx;
        wload_idx  = wl_idx_nx;
        wload_data = wl_data_nx;
        @(negedge clk);
        if (rst_n) monitor();
    endtask

    task automatic load_weights();
        for (int k = 0; k < NK; k++) begin
            wl_en_nx   = 1'b1;
            wl_idx_nx  = 3'(k);
            wl_data_nx = exp_w[k];
            tick();
        end
        tick();
        tick();
    endtask

    task automatic run_frame(input bit stl, input bit spam, input int lim, input int exp_clr,
                             input int exp_pix, input int exp_res, input bit exp_err,
                             input bit wl_busy);
        int b;
        frame_reset();
        stall_mode     = stl;
        spam_mode      = spam;
        pool_limit     = lim;
        exp_stream_len = stl ? 1176 : 784;
        start_nx = 1'b1;
        tick();
        b = 0;
        while (done_cnt == 0 && b < 40000) begin
            if (wl_busy && b == 5) begin
                wl_en_nx   = 1'b1;
                wl_idx_nx  = 3'd0;
                wl_data_nx = ~exp_w[0];
            end
            tick();
            b++;
        end
        repeat (4) tick();
        check("done_cnt", 32'(done_cnt), 32'(1));
        check("clear_cnt", 32'(clear_cnt), 32'(exp_clr));
        check("pix_total", 32'(pix_total), 32'(exp_pix));
        check("res_total", 32'(res_total), 32'(exp_res));
        check("error", 32'(error), 32'(exp_err));
        check("busy_after", 32'(busy), 32'(0));
        check("res_pending", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        int b;
        rst_n = 1'b0;
        start = 0; stall = 0; wload_en = 0; wload_idx = 0; wload_data = 0;
        pool_valid = 0; pool_out = 0;
        start_nx = 0; stall_nx = 0; pool_nx = 0; pool_out_nx = 0;
        wl_en_nx = 0; wl_idx_nx = 0; wl_data_nx = 0;
        stall_mode = 0; spam_mode = 0; pool_limit = NpoolT; exp_stream_len = NpixT;
        frame_reset();
        for (int k = 0; k < NK; k++) exp_w[k] = 9'((k * 83 + 37) ^ 341);

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_error", 32'(error), 32'(0));
        check("rst_rd_en", 32'(img_rd_en), 32'(0));
        check("rst_clear", 32'(pipe_clear), 32'(0));
        check("rst_res_valid", 32'(res_valid), 32'(0));
        check("rst_weights", 32'(weight_bits), 32'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;

        load_weights();
        check("idle_weight0", 32'(weight_bits), 32'(exp_w[0]));

        // Full frame, start held high through every DRAIN/NEXT/DONE after the first stream.
        run_frame(0, 1, NpoolT, 8, 8 * NpixT, 8 * NpoolT, 0, 0);
        // Stall every third stream cycle, plus a weight write attempt while busy.
        run_frame(1, 0, NpoolT, 8, 8 * NpixT, 8 * NpoolT, 0, 1);
        // Datapath stops after 100 results: drain timeout on kernel 0.
        run_frame(0, 0, 100, 1, NpixT, 100, 1, 0);
        check("err_delay", 32'(err_delay), 32'(1024));

        // Reset in the middle of kernel 3.
        frame_reset();
        stall_mode = 0; spam_mode = 0; pool_limit = NpoolT; exp_stream_len = NpixT;
        start_nx = 1'b1;
        tick();
        tick();
        tick();
        check("error_cleared", 32'(error), 32'(0));
        check("busy_running", 32'(busy), 32'(1));
        b = 0;
        while (!(clear_cnt == 4 && pix_seen >= 50) && b < 20000) begin
            tick();
            b++;
        end
        check("reached_kernel3", 32'(mk), 32'(3));
        #2 rst_n = 1'b0;
        #1;
        check("ar_rd_en", 32'(img_rd_en), 32'(0));
        check("ar_addr", 32'(img_addr), 32'(0));
        check("ar_pix_valid", 32'(pix_valid), 32'(0));
        check("ar_pix_out", 32'(pix_out), 32'(0));
        check("ar_clear", 32'(pipe_clear), 32'(0));
        check("ar_res", 32'({res_valid, res_data, res_kernel, res_index}), 32'(0));
        check("ar_status", 32'({busy, done, error}), 32'(0));
        check("ar_weights", 32'(weight_bits), 32'(0));
        start = 0; stall = 0; pool_valid = 0; pool_out = 0; wload_en = 0;
        start_nx = 0; stall_nx = 0; pool_nx = 0; wl_en_nx = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        frame_reset();
        repeat (20) tick();
        check("no_done_after_reset", 32'(done_cnt), 32'(0));
        check("idle_after_reset", 32'(busy), 32'(0));

        for (int k = 0; k < NK; k++) exp_w[k] = 9'(k * 61 + 200);
        load_weights();
        check("reload_weight0", 32'(weight_bits), 32'(exp_w[0]));
        run_frame(0, 0, NpoolT, 8, 8 * NpixT, 8 * NpoolT, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
